// File: rtl/i2c_calc_pkg.sv
// Shared types and register map for the I2C calculator target.
package i2c_calc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [2:0] REG_OP     = 3'd0;
  localparam logic [2:0] REG_A      = 3'd1;
  localparam logic [2:0] REG_B      = 3'd2;
  localparam logic [2:0] REG_RES_LO = 3'd3;
  localparam logic [2:0] REG_RES_HI = 3'd4;

  // Read view of the register map; unmapped locations and unused op bits read as zero.
  function automatic logic [7:0] reg_read(
    input logic [2:0]  ptr,
    input logic [1:0]  op,
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [15:0] res
  );
    logic [7:0] val;
    val = 8'h00;
    case (ptr)
      REG_OP:     val = {6'b0, op};
      REG_A:      val = a;
      REG_B:      val = b;
      REG_RES_LO: val = res[7:0];
      REG_RES_HI: val = res[15:8];
      default:    val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA pad synchronizer with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Synchronizer chains plus one delayed copy of each line for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to the idle-bus level so releasing reset never looks like a START.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;

  // SCL must be high on both samples, so an SDA change coinciding with an SCL
  // edge is treated as data, not as a bus condition.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_calc_target.sv
// I2C target front end: register file for opcode/operands, read-back of the 16-bit result.
module i2c_calc_target
  import i2c_calc_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [1:0]  op_o,
  output logic [7:0]  a_o,
  output logic [7:0]  b_o,
  output logic        go_o,
  input  logic [15:0] result_i,
  output logic        busy_o
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state;
  i2c_state_e state_next;

  logic [3:0]  bit_cnt;
  logic        bit_done;
  logic [7:0]  shift;
  logic [7:0]  tx_shift;
  logic [2:0]  pointer;
  logic [2:0]  ptr_inc;
  logic        ack_bit;
  logic [15:0] shadow;
  logic        wrote;
  logic [7:0]  rd_byte;

  logic        addr_match;
  logic        bus_end;
  logic        shift_in;
  logic        snapshot;
  logic        ptr_load;
  logic        ptr_advance;
  logic        byte_accept;
  logic        rd_load;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign bit_done   = (bit_cnt == 4'd8);
  assign addr_match = (shift[7:1] == TARGET_ADDR);
  assign ptr_inc    = pointer + 3'd1;
  assign bus_end    = start_det | stop_det;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; byte phases end on the SCL fall after the 8th bit,
  // ACK phases on the following SCL fall. START/STOP override everything.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_ADDR:     if (scl_fall && bit_done) state_next = addr_match ? ST_ADDR_ACK : ST_IGNORE;
      ST_ADDR_ACK: if (scl_fall)             state_next = shift[0] ? ST_RD_DATA : ST_PTR;
      ST_PTR:      if (scl_fall && bit_done) state_next = ST_PTR_ACK;
      ST_PTR_ACK:  if (scl_fall)             state_next = ST_WR_DATA;
      ST_WR_DATA:  if (scl_fall && bit_done) state_next = ST_WR_ACK;
      ST_WR_ACK:   if (scl_fall)             state_next = ST_WR_DATA;
      ST_RD_DATA:  if (scl_fall && bit_done) state_next = ST_RD_ACK;
      ST_RD_ACK:   if (scl_fall)             state_next = ack_bit ? ST_IGNORE : ST_RD_DATA;
      default:     state_next = state;
    endcase
    if (start_det)     state_next = ST_ADDR;
    else if (stop_det) state_next = ST_IDLE;
  end

  // Transition strobes driving the datapath.
  assign shift_in    = scl_rise && !bit_done &&
                       (state inside {ST_ADDR, ST_PTR, ST_WR_DATA});
  assign snapshot    = (state == ST_ADDR)    && (state_next == ST_ADDR_ACK) && shift[0];
  assign ptr_load    = (state == ST_PTR)     && (state_next == ST_PTR_ACK);
  assign byte_accept = (state == ST_WR_DATA) && (state_next == ST_WR_ACK);
  assign ptr_advance = ((state == ST_WR_ACK) && (state_next == ST_WR_DATA)) ||
                       ((state == ST_RD_ACK) && (state_next == ST_RD_DATA));
  assign rd_load     = (state != ST_RD_DATA) && (state_next == ST_RD_DATA);

  // Byte to transmit next: current pointer after the address ACK, pointer+1 after a read ACK.
  assign rd_byte = reg_read((state == ST_RD_ACK) ? ptr_inc : pointer, op_o, a_o, b_o, shadow);

  assign busy_o = state inside {ST_ADDR_ACK, ST_PTR, ST_PTR_ACK, ST_WR_DATA,
                                ST_WR_ACK, ST_RD_DATA, ST_RD_ACK};

  // Bit counter, receive shift register and controller ACK sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      ack_bit <= 1'b1;
    end else begin
      if (start_det || (state_next != state)) begin
        bit_cnt <= 4'd0;
      end else if (scl_rise && !bit_done &&
                   (state inside {ST_ADDR, ST_PTR, ST_WR_DATA, ST_RD_DATA})) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (shift_in)                           shift   <= {shift[6:0], sda_s};
      if (scl_rise && (state == ST_RD_ACK))   ack_bit <= sda_s;
    end
  end

  // Transmit shifter and open-drain enable; the enable only moves on SCL fall
  // (or is released by a bus condition) so it never creates a false START/STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= 8'h00;
      sda_oe   <= 1'b0;
    end else begin
      if (rd_load)                                     tx_shift <= rd_byte;
      else if (scl_fall && (state == ST_RD_DATA) &&
               (state_next == ST_RD_DATA))             tx_shift <= {tx_shift[6:0], 1'b0};

      if (bus_end) begin
        sda_oe <= 1'b0;
      end else if (scl_fall) begin
        case (state_next)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: sda_oe <= 1'b1;
          ST_RD_DATA: sda_oe <= rd_load ? ~rd_byte[7] : ~tx_shift[6];
          default:    sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Register pointer: loaded by the pointer byte, advanced per accepted/ACKed data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pointer <= 3'd0;
    else if (ptr_load)    pointer <= shift[2:0];
    else if (ptr_advance) pointer <= ptr_inc;
  end

  // Register file, result shadow and commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these few registers are architectural outputs, so they are reset (unlike a RAM array).
      op_o   <= 2'd0;
      a_o    <= 8'h00;
      b_o    <= 8'h00;
      shadow <= 16'h0000;
      wrote  <= 1'b0;
      go_o   <= 1'b0;
    end else begin
      go_o <= bus_end & wrote;
      if (snapshot) shadow <= result_i;
      if (bus_end) begin
        wrote <= 1'b0;
      end else if (byte_accept) begin
        case (pointer)
          REG_OP: begin op_o <= shift[1:0]; wrote <= 1'b1; end
          REG_A:  begin a_o  <= shift;      wrote <= 1'b1; end
          REG_B:  begin b_o  <= shift;      wrote <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_calc_target.sv
// Self-checking bench: bit-banged I2C controller against a register-map level model.
module tb_i2c_calc_target;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic        clk;
  logic        rst_n;
  logic        scl;
  logic        sda_ctrl;
  logic        sda_line;
  logic        sda_oe;
  logic [1:0]  op_o;
  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic        go_o;
  logic [15:0] result_i;
  logic        busy_o;

  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_calc_target #(
    .TARGET_ADDR (7'h2A),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .op_o     (op_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .go_o     (go_o),
    .result_i (result_i),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitors.
  int   go_count  = 0;
  bit   busy_seen = 0;
  int   oe_glitch = 0;
  logic oe_prev   = 1'b0;
  always @(negedge clk) begin
    if (go_o) go_count++;
    if (busy_o) busy_seen = 1;
    if (rst_n && scl && (sda_oe !== oe_prev)) oe_glitch++;
    oe_prev = sda_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model of the register map.
  logic [1:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [2:0] m_ptr;

  function automatic int model_write(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] d [4];
    int any;
    d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
    any = 0;
    if (n == 0) return 0;
    m_ptr = d[0][2:0];
    for (int i = 1; i < n; i++) begin
      if (m_ptr == 3'd0) m_op = d[i][1:0];
      if (m_ptr == 3'd1) m_a  = d[i];
      if (m_ptr == 3'd2) m_b  = d[i];
      if (m_ptr <= 3'd2) any = 1;
      m_ptr = m_ptr + 3'd1;
    end
    return any;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] p, input logic [15:0] res);
    if (p == 3'd0) return {6'b0, m_op};
    if (p == 3'd1) return m_a;
    if (p == 3'd2) return m_b;
    if (p == 3'd3) return res[7:0];
    if (p == 3'd4) return res[15:8];
    return 8'h00;
  endfunction

  // Bit-level controller.
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic bus_stop();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    sda_ctrl = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_ctrl = b; wait_q();
    scl = 1'b1;   wait_q(); wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_ctrl = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    b = sda_line;    wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic bv;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bv);
      d[i] = bv;
    end
    write_bit(nack);
  endtask

  // Write transaction to our address: pointer byte plus n-1 data bytes, then STOP.
  task automatic write_regs(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, input string tag,
                            output int go_delta);
    logic [7:0] d [4];
    logic ack;
    int nacks, g0, exp_go;
    d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
    g0 = go_count;
    nacks = 0;
    bus_start();
    write_byte(8'h54, ack); nacks += int'(ack);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack); nacks += int'(ack);
    end
    bus_stop();
    wait_q();
    exp_go   = model_write(b0, b1, b2, b3, n);
    go_delta = go_count - g0;
    check({tag, " nacks"}, nacks, 0);
    check({tag, " go pulses"}, go_delta, exp_go);
    check({tag, " op_o"}, op_o, m_op);
    check({tag, " a_o"}, a_o, m_a);
    check({tag, " b_o"}, b_o, m_b);
  endtask

  // Read transaction of k bytes (last one NACKed), compared to the model.
  task automatic read_regs(input logic [15:0] res, input int k, input string tag,
                           output logic [7:0] got [4]);
    logic ack;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    result_i = res;
    bus_start();
    write_byte(8'h55, ack);
    check({tag, " addr ack"}, ack, 0);
    for (int i = 0; i < k; i++) begin
      exp = model_read(m_ptr, res);
      read_byte(got[i], (i == k - 1));
      check($sformatf("%s byte%0d", tag, i), got[i], exp);
      if (i != k - 1) m_ptr = m_ptr + 3'd1;
    end
    check({tag, " sda released"}, sda_oe, 0);
    bus_stop();
    wait_q();
  endtask

  typedef struct {
    logic [7:0]  ptr;
    logic [7:0]  data;
    logic [15:0] res;
    logic [7:0]  exp_rd;
    int          exp_go;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic       ack;
    logic       bv;
    logic [7:0] rb0, rb1;
    logic [7:0] got [4];
    int         nacks, g0, gd;

    vecs[0] = '{8'h00, 8'hFF, 16'h0000, 8'h03, 1};
    vecs[1] = '{8'h01, 8'hA5, 16'h0000, 8'hA5, 1};
    vecs[2] = '{8'h02, 8'h3C, 16'h0000, 8'h3C, 1};
    vecs[3] = '{8'h03, 8'h77, 16'h1234, 8'h34, 0};
    vecs[4] = '{8'h04, 8'h77, 16'h1234, 8'h12, 0};
    vecs[5] = '{8'h05, 8'h99, 16'hFFFF, 8'h00, 0};
    vecs[6] = '{8'h0F, 8'h11, 16'hFFFF, 8'h00, 0};

    scl = 1'b1; sda_ctrl = 1'b1; rst_n = 1'b0; result_i = 16'h0000;
    m_op = 2'd0; m_a = 8'h00; m_b = 8'h00; m_ptr = 3'd0;
    repeat (3) @(negedge clk);
    check("reset sda_oe", sda_oe, 0);
    check("reset op_o", op_o, 0);
    check("reset a_o", a_o, 0);
    check("reset b_o", b_o, 0);
    check("reset go_o", go_o, 0);
    check("reset busy_o", busy_o, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full write: ptr 0, op=2, A=0x10, B=0x05.
    g0 = go_count; nacks = 0;
    bus_start();
    write_byte(8'h54, ack); nacks += int'(ack);
    check("t1 busy after addr ack", busy_o, 1);
    write_byte(8'h00, ack); nacks += int'(ack);
    write_byte(8'h02, ack); nacks += int'(ack);
    write_byte(8'h10, ack); nacks += int'(ack);
    write_byte(8'h05, ack); nacks += int'(ack);
    bus_stop(); wait_q();
    void'(model_write(8'h00, 8'h02, 8'h10, 8'h05, 4));
    check("t1 nacks", nacks, 0);
    check("t1 op_o", op_o, 2);
    check("t1 a_o", a_o, 8'h10);
    check("t1 b_o", b_o, 8'h05);
    check("t1 go pulses", go_count - g0, 1);
    check("t1 busy after stop", busy_o, 0);

    // Pointer write, repeated START, read result bytes.
    g0 = go_count; nacks = 0; result_i = 16'hABCD;
    bus_start();
    write_byte(8'h54, ack); nacks += int'(ack);
    write_byte(8'h03, ack); nacks += int'(ack);
    bus_start();
    write_byte(8'h55, ack); nacks += int'(ack);
    read_byte(rb0, 1'b0);
    read_byte(rb1, 1'b1);
    check("t2 sda released after nack", sda_oe, 0);
    check("t2 busy after nack", busy_o, 0);
    bus_stop(); wait_q();
    m_ptr = 3'd4;
    check("t2 nacks", nacks, 0);
    check("t2 byte0", rb0, 8'hCD);
    check("t2 byte1", rb1, 8'hAB);
    check("t2 no go", go_count - g0, 0);

    // Foreign address: no ACK, nothing written, never busy.
    g0 = go_count; busy_seen = 0;
    bus_start();
    write_byte(8'h56, rb0[0]);
    write_byte(8'h01, rb0[1]);
    bus_stop(); wait_q();
    check("t3 addr nack", rb0[0], 1);
    check("t3 data nack", rb0[1], 1);
    check("t3 busy never", busy_seen, 0);
    check("t3 go none", go_count - g0, 0);
    check("t3 op_o", op_o, m_op);
    check("t3 a_o", a_o, m_a);
    check("t3 b_o", b_o, m_b);

    // Pointer 7 wraps to 0 on read.
    write_regs(8'h07, 8'h00, 8'h00, 8'h00, 1, "t4 ptr", gd);
    read_regs(16'h0000, 2, "t4 rd", got);
    check("t4 wrap byte0", got[0], 8'h00);
    check("t4 wrap byte1", got[1], 8'h02);

    // Result changes between bytes; shadow keeps the captured value.
    write_regs(8'h03, 8'h00, 8'h00, 8'h00, 1, "t5 ptr", gd);
    result_i = 16'hABCD;
    bus_start();
    write_byte(8'h55, ack);
    check("t5 addr ack", ack, 0);
    read_byte(rb0, 1'b0);
    result_i = 16'h1234;
    read_byte(rb1, 1'b1);
    bus_stop(); wait_q();
    m_ptr = 3'd4;
    check("t5 byte0", rb0, 8'hCD);
    check("t5 byte1", rb1, 8'hAB);

    // Table: write one byte, re-point, read it back.
    for (int v = 0; v < 7; v++) begin
      write_regs(vecs[v].ptr, vecs[v].data, 8'h00, 8'h00, 2, $sformatf("vec%0d wr", v), gd);
      check($sformatf("vec%0d go", v), gd, vecs[v].exp_go);
      write_regs(vecs[v].ptr, 8'h00, 8'h00, 8'h00, 1, $sformatf("vec%0d ptr", v), gd);
      read_regs(vecs[v].res, 1, $sformatf("vec%0d rd", v), got);
      check($sformatf("vec%0d readback", v), got[0], vecs[v].exp_rd);
    end

    // Randomized write/read transactions against the model.
    for (int it = 0; it < 10; it++) begin
      int n;
      int k;
      n = int'($urandom_range(1, 4));
      k = int'($urandom_range(1, 3));
      write_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n,
                 $sformatf("rnd%0d wr", it), gd);
      read_regs(16'($urandom), k, $sformatf("rnd%0d rd", it), got);
    end

    // Reset while the target drives read data bit 0.
    write_regs(8'h01, 8'hFE, 8'h00, 8'h00, 2, "rst pre", gd);
    write_regs(8'h01, 8'h00, 8'h00, 8'h00, 1, "rst ptr", gd);
    bus_start();
    write_byte(8'h55, ack);
    check("rst addr ack", ack, 0);
    for (int i = 0; i < 7; i++) read_bit(bv);
    check("rst driving bit0", sda_oe, 1);
    check("rst busy before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst sda_oe", sda_oe, 0);
    check("rst busy_o", busy_o, 0);
    check("rst op_o", op_o, 0);
    check("rst a_o", a_o, 0);
    check("rst b_o", b_o, 0);
    check("rst go_o", go_o, 0);
    @(negedge clk);
    scl = 1'b1; sda_ctrl = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_op = 2'd0; m_a = 8'h00; m_b = 8'h00; m_ptr = 3'd0;
    write_regs(8'h02, 8'h5A, 8'h00, 8'h00, 2, "post rst wr", gd);
    write_regs(8'h01, 8'h00, 8'h00, 8'h00, 1, "post rst ptr", gd);
    read_regs(16'h0000, 2, "post rst rd", got);

    check("sda_oe stable while scl high", oe_glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
